// File: rtl/shift_add_mult_ctrl_if.sv
// Operand/result handshake bundle for the sequential 4x4 shift-add multiplier.
// Valid/ready: an operand pair is taken on a rising edge where start=1 and ready=1;
// start while ready=0 is dropped, and done is a one-cycle pulse marking a fresh product.
interface shift_add_mult_ctrl_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       ready;
    logic       done;
    logic [7:0] product;

    modport master (
        output start, a, b,
        input  ready, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, done, product
    );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Sequential 4x4 unsigned multiplier: one shared 4-bit adder, four shift-add
// iterations per operand pair, product registered and pulsed out with done.
module four_bit_adder (
    input  logic [3:0] i_in1,
    input  logic [3:0] i_in2,
    output logic [4:0] o_sum
);
    assign o_sum = {1'b0, i_in1} + {1'b0, i_in2};
endmodule

module shift_add_mult_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    shift_add_mult_ctrl_if.slave   s_bus,
    output logic [1:0]             o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_m;
    logic [3:0]  r_q;
    logic [3:0]  r_acc;
    logic [1:0]  r_cnt;
    logic [7:0]  r_product;
    logic        r_done;
    logic [4:0]  w_sum;
    logic [4:0]  w_t;

    four_bit_adder u_adder (
        .i_in1 (r_acc),
        .i_in2 (r_m),
        .o_sum (w_sum)
    );

    // Partial product for this iteration; the carry stays in bit 4 so nothing overflows.
    assign w_t = r_q[0] ? w_sum : {1'b0, r_acc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_m       <= 4'd0;
            r_q       <= 4'd0;
            r_acc     <= 4'd0;
            r_cnt     <= 2'd0;
            r_product <= 8'd0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (s_bus.start) begin
                        r_m     <= s_bus.a;
                        r_q     <= s_bus.b;
                        r_acc   <= 4'd0;
                        r_cnt   <= 2'd0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_t[4:1];
                    r_q   <= {w_t[0], r_q[3:1]};
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_product <= {w_t[4:1], w_t[0], r_q[3:1]};
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_bus.ready   = (r_state == S_IDLE);
    assign s_bus.done    = r_done;
    assign s_bus.product = r_product;
    assign o_dbg_state   = r_state;
endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
Sequential 4x4 unsigned multiplier controller that time-shares a single four_bit_adder instance across four shift-add iterations. It is the area-reduced alternative to the combinational 4-bit multiplier: one adder instead of an adder array, at the cost of multi-cycle latency. It accepts operands through a start/ready handshake and presents an 8-bit product with a one-cycle done pulse.

Parameters:
none (operand width is fixed at 4 by the shared four_bit_adder datapath)

Ports:
clk      input   1  system clock, all state updates on rising edge
rst      input   1  asynchronous, active-high reset
start    input   1  request; sampled only when ready=1
a        input   4  multiplicand, unsigned, captured with start
b        input   4  multiplier, unsigned, captured with start
ready    output  1  high when controller can accept start (IDLE only)
done     output  1  one-cycle pulse: product updated this cycle
product  output  8  registered result, held until next completion

Behaviour:
- Reset (async, rst=1): state=IDLE; acc, q, m, cnt, product all 0; done=0; ready=1 (combinational from IDLE). Reset mid-operation aborts with no done pulse; product returns to 0.
- Internal regs: m[3:0] multiplicand, q[3:0] multiplier/low product, acc[3:0] high partial product, cnt[1:0] iteration count.
- Adder hookup: the single four_bit_adder has in1=acc, in2=m, out=sum[4:0]. There is no carry-in, and it is the only adder in the block.
- States: IDLE, RUN, DONE. State register and outputs are Moore.
- IDLE: ready=1. On an edge with start=1: m<=a, q<=b, acc<=0, cnt<=0, go to RUN. With start=0: hold.
- RUN: ready=0.
  - Each edge: t = q[0] ? sum : {1'b0, acc} (5 bits).
  - {acc, q} <= {t, q[3:1]}. This is a 9-bit right shift, so acc<=t[4:1] and q<={t[0], q[3:1]}.
  - cnt<=cnt+1.
  - On the edge where cnt==3: also product<={t[4:1], t[0], q[3:1]} (the post-shift value), then go to DONE.
- DONE: ready=0, done=1 for exactly one cycle. Next edge goes unconditionally to IDLE, and done drops.
- Latency: the start-sampling edge is E0. Iterations happen on E1..E4. done=1 and the new product are visible in the cycle after E4. ready returns after E5. Minimum issue interval is 6 cycles.
- start while ready=0 (RUN or DONE) is ignored, not queued. a and b changes during RUN have no effect because they are captured at E0.
- Width rules:
  - A carry out of the adder (sum[4]) is kept via t[4], so there is no overflow.
  - The maximum product is 15*15=225 and fits in 8 bits.
  - cnt wraps 3->0 harmlessly because it is reloaded on every start.
- Product is updated only at iteration 4 or reset. It is never partially visible.

Test Plan:
- Reset, then start with a=15, b=15 for 1 cycle -> ready falls at E0+; done=1 exactly one cycle after E4; product=225 (0xE1); ready=1 after E5.
- a=10, b=6 -> product=60 (0x3C). a=0, b=13 -> product=0. a=1, b=15 -> product=15. done pulses once per operation.
- Exhaustive sweep of all 256 (a,b) pairs back-to-back, restarting on each ready -> product==a*b every time; consecutive done pulses exactly 6 cycles apart.
- Start a=3, b=5, then pulse start with a=7, b=7 and change a/b during RUN -> result is 15 (0x0F); second start produces no extra done.
- Assert rst at E2 of an operation a=9, b=9, mid-cycle and asynchronous -> outputs zero immediately; no done; ready=1 after release. A fresh start a=9, b=9 then gives 81 (0x51).
- Hold start=1 continuously with a=2, b=3 -> new operation accepted every 6 cycles; each done shows product=6; product is stable between done pulses.
